operand_accumulator: RTL and testbench

- Downstream of the digit-entry FSM. Captures one BCD digit per `digit_enable` pulse into a 4-digit shift register that drives the display.
- On `operand_done`, converts the held BCD value to binary by iterative multiply-by-10 accumulation. Stores the result as operand A, then operand B.
- Presents the operand pair to the ALU with a valid/ack handshake.

---
 rtl/operand_accumulator.sv | 133 +++++++++++++
 tb/tb_operand_accumulator.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/operand_accumulator.sv
// Operand accumulator: collects BCD digits into a display shift register,
// converts each completed entry to binary (operand A, then operand B) and
// offers the pair to the ALU with a valid/ack handshake.
// Latency: operand_done to operand register write is DIGITS+1 edges.
// Backpressure: busy is high while converting or while the pair awaits alu_ack;
// digit_enable/operand_done are ignored then.
// Ports: clk/reset (sync, active-high); digit_in/digit_enable/operand_done from
// the entry FSM; clear (user clear); alu_ack; display_bcd, operand_a/b,
// operands_valid, busy, digit_err outputs.
module operand_accumulator #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            digit_in,
  input  logic                  digit_enable,
  input  logic                  operand_done,
  input  logic                  clear,
  input  logic                  alu_ack,
  output logic [4*DIGITS-1:0]   display_bcd,
  output logic [BIN_W-1:0]      operand_a,
  output logic [BIN_W-1:0]      operand_b,
  output logic                  operands_valid,
  output logic                  busy,
  output logic                  digit_err
);

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {COLLECT, CONVERT, PAIR_VALID} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   count;
  logic [IDX_W-1:0]   idx;
  logic [BIN_W-1:0]   acc;
  logic [BIN_W-1:0]   acc_next;
  logic [3:0]         nib;
  logic               slot_b;     // 0: next result goes to A, 1: to B
  logic               digit_ok;
  logic               capture;
  logic               last_step;

  assign digit_ok  = (digit_in <= 4'd9);
  assign capture   = (state == COLLECT) && digit_enable && digit_ok &&
                     (count < CNT_W'(DIGITS));
  assign last_step = (state == CONVERT) && (idx == IDX_W'(DIGITS - 1));

  // Most significant nibble is consumed first.
  always_comb begin
    nib      = display_bcd[4*(DIGITS-1-int'(idx)) +: 4];
    acc_next = acc * BIN_W'(10) + BIN_W'(nib);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_next;
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = COLLECT;
    end else begin
      case (state)
        COLLECT:    if (operand_done) state_next = CONVERT;
        CONVERT:    if (last_step)    state_next = slot_b ? PAIR_VALID : COLLECT;
        PAIR_VALID: if (alu_ack)      state_next = COLLECT;
        default:                      state_next = COLLECT;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    busy           = (state != COLLECT);
    operands_valid = (state == PAIR_VALID);
  end

  // Datapath: digit capture, conversion accumulator, operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      display_bcd <= '0;
      count       <= '0;
      idx         <= '0;
      acc         <= '0;
      slot_b      <= 1'b0;
      operand_a   <= '0;
      operand_b   <= '0;
      digit_err   <= 1'b0;
    end else begin
      digit_err <= 1'b0;
      if (clear) begin
        // Operands are retained; an in-flight conversion is simply dropped.
        display_bcd <= '0;
        count       <= '0;
        idx         <= '0;
        acc         <= '0;
        slot_b      <= 1'b0;
      end else begin
        case (state)
          COLLECT: begin
            if (digit_enable && !digit_ok) digit_err <= 1'b1;
            if (capture) begin
              display_bcd <= {display_bcd[4*DIGITS-5:0], digit_in};
              count       <= count + CNT_W'(1);
            end
            if (operand_done) begin
              idx <= '0;
              acc <= '0;
            end
          end
          CONVERT: begin
            acc <= acc_next;
            idx <= idx + IDX_W'(1);
            if (last_step) begin
              if (slot_b) operand_b <= acc_next;
              else        operand_a <= acc_next;
              slot_b      <= ~slot_b;
              display_bcd <= '0;
              count       <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand_accumulator.sv
module tb_operand_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  digit_in = 4'd0;
  logic        digit_enable = 1'b0;
  logic        operand_done = 1'b0;
  logic        clear = 1'b0;
  logic        alu_ack = 1'b0;
  logic [15:0] display_bcd;
  logic [13:0] operand_a;
  logic [13:0] operand_b;
  logic        operands_valid;
  logic        busy;
  logic        digit_err;

  int vectors = 0;
  int miscompares = 0;

  operand_accumulator #(.DIGITS(4), .BIN_W(14)) dut (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_enable(digit_enable),
    .operand_done(operand_done), .clear(clear), .alu_ack(alu_ack),
    .display_bcd(display_bcd), .operand_a(operand_a), .operand_b(operand_b),
    .operands_valid(operands_valid), .busy(busy), .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_digit(input logic [3:0] d);
    digit_in = d; digit_enable = 1'b1;
    tick();
    digit_enable = 1'b0;
  endtask

  task automatic pulse_done();
    operand_done = 1'b1;
    tick();
    operand_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    vectors++; if (display_bcd !== 16'h0) begin miscompares++; $display("FAIL rst_display: got %h want 0000", display_bcd); end
    vectors++; if (operand_a !== 14'd0) begin miscompares++; $display("FAIL rst_a: got %0d want 0", operand_a); end
    vectors++; if (operand_b !== 14'd0) begin miscompares++; $display("FAIL rst_b: got %0d want 0", operand_b); end
    vectors++; if ({operands_valid, busy, digit_err} !== 3'b000) begin miscompares++; $display("FAIL rst_flags: got %b want 000", {operands_valid, busy, digit_err}); end
  endtask

  task automatic test_first_operand();
    enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3); enter_digit(4'd4);
    vectors++; if (display_bcd !== 16'h1234) begin miscompares++; $display("FAIL disp_1234: got %h want 1234", display_bcd); end
    pulse_done();                       // edge 1: enter CONVERT
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_convert: got %b want 1", busy); end
    tick(); tick(); tick();             // edges 2..4
    vectors++; if (operand_a !== 14'd0) begin miscompares++; $display("FAIL a_early: got %0d want 0", operand_a); end
    tick();                             // edge 5: write
    vectors++; if (operand_a !== 14'd1234) begin miscompares++; $display("FAIL a_1234: got %0d want 1234", operand_a); end
    vectors++; if (display_bcd !== 16'h0) begin miscompares++; $display("FAIL disp_clr_a: got %h want 0000", display_bcd); end
    vectors++; if ({busy, operands_valid} !== 2'b00) begin miscompares++; $display("FAIL flags_after_a: got %b want 00", {busy, operands_valid}); end
  endtask

  task automatic test_second_operand();
    for (int i = 0; i < 4; i++) enter_digit(4'd9);
    pulse_done();
    tick(); tick(); tick(); tick();
    vectors++; if (operand_b !== 14'd9999) begin miscompares++; $display("FAIL b_9999: got %0d want 9999", operand_b); end
    vectors++; if ({operands_valid, busy} !== 2'b11) begin miscompares++; $display("FAIL pair_flags: got %b want 11", {operands_valid, busy}); end
    vectors++; if (operand_a !== 14'd1234) begin miscompares++; $display("FAIL a_held: got %0d want 1234", operand_a); end
    enter_digit(4'd5);                  // ignored while pair valid
    pulse_done();                       // ignored while pair valid
    vectors++; if (display_bcd !== 16'h0) begin miscompares++; $display("FAIL disp_in_pair: got %h want 0000", display_bcd); end
    vectors++; if (operands_valid !== 1'b1) begin miscompares++; $display("FAIL valid_hold: got %b want 1", operands_valid); end
    alu_ack = 1'b1; tick(); alu_ack = 1'b0;
    vectors++; if ({operands_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL after_ack: got %b want 00", {operands_valid, busy}); end
    alu_ack = 1'b1; tick(); alu_ack = 1'b0;  // no effect when not valid
    vectors++; if ({operands_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL stray_ack: got %b want 00", {operands_valid, busy}); end
  endtask

  task automatic test_short_and_full();
    enter_digit(4'd7); enter_digit(4'd5);
    vectors++; if (display_bcd !== 16'h0075) begin miscompares++; $display("FAIL disp_75: got %h want 0075", display_bcd); end
    pulse_done(); tick(); tick(); tick(); tick();
    vectors++; if (operand_a !== 14'd75) begin miscompares++; $display("FAIL a_75: got %0d want 75", operand_a); end
    enter_digit(4'd5); enter_digit(4'd6); enter_digit(4'd7); enter_digit(4'd8); enter_digit(4'd3);
    vectors++; if (display_bcd !== 16'h5678) begin miscompares++; $display("FAIL disp_full: got %h want 5678", display_bcd); end
    vectors++; if (digit_err !== 1'b0) begin miscompares++; $display("FAIL err_full: got %b want 0", digit_err); end
    pulse_done(); tick(); tick(); tick(); tick();
    vectors++; if (operand_b !== 14'd5678) begin miscompares++; $display("FAIL b_5678: got %0d want 5678", operand_b); end
    alu_ack = 1'b1; tick(); alu_ack = 1'b0;
  endtask

  task automatic test_digit_err();
    enter_digit(4'd1);
    enter_digit(4'hC);
    vectors++; if (digit_err !== 1'b1) begin miscompares++; $display("FAIL err_pulse: got %b want 1", digit_err); end
    vectors++; if (display_bcd !== 16'h0001) begin miscompares++; $display("FAIL err_disp: got %h want 0001", display_bcd); end
    tick();
    vectors++; if (digit_err !== 1'b0) begin miscompares++; $display("FAIL err_one_cycle: got %b want 0", digit_err); end
    pulse_done();                       // edge 1
    enter_digit(4'd3);                  // edge 2, ignored during CONVERT
    tick(); tick(); tick();             // edges 3..5
    vectors++; if (operand_a !== 14'd1) begin miscompares++; $display("FAIL a_1: got %0d want 1", operand_a); end
    vectors++; if (display_bcd !== 16'h0) begin miscompares++; $display("FAIL disp_after_1: got %h want 0000", display_bcd); end
  endtask

  task automatic test_clear_abort();
    // Slot is B here; clear must abort and steer the next result to A.
    enter_digit(4'd2); enter_digit(4'd2);
    pulse_done(); tick();               // in 2nd CONVERT cycle
    clear = 1'b1; tick(); clear = 1'b0;
    vectors++; if ({busy, display_bcd} !== 17'h0) begin miscompares++; $display("FAIL clr_state: got %b/%h want 0/0000", busy, display_bcd); end
    tick(); tick(); tick();
    vectors++; if (operand_b !== 14'd5678) begin miscompares++; $display("FAIL clr_b_kept: got %0d want 5678", operand_b); end
    vectors++; if (operand_a !== 14'd1) begin miscompares++; $display("FAIL clr_a_kept: got %0d want 1", operand_a); end
    enter_digit(4'd4); enter_digit(4'd2);
    pulse_done(); tick(); tick(); tick(); tick();
    vectors++; if (operand_a !== 14'd42) begin miscompares++; $display("FAIL a_42_after_clr: got %0d want 42", operand_a); end
    vectors++; if (operands_valid !== 1'b0) begin miscompares++; $display("FAIL clr_slot_valid: got %b want 0", operands_valid); end
  endtask

  task automatic test_back_to_back();
    // Slot is B; last digit arrives with operand_done.
    enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3);
    digit_in = 4'd4; digit_enable = 1'b1; operand_done = 1'b1;
    tick();
    digit_enable = 1'b0; operand_done = 1'b0;
    tick(); tick(); tick(); tick();
    vectors++; if (operand_b !== 14'd1234) begin miscompares++; $display("FAIL b_same_cycle: got %0d want 1234", operand_b); end
    vectors++; if (operands_valid !== 1'b1) begin miscompares++; $display("FAIL valid_same_cycle: got %b want 1", operands_valid); end
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++; if ({operand_a, operand_b} !== 28'h0) begin miscompares++; $display("FAIL mid_rst_ops: got %0d/%0d want 0/0", operand_a, operand_b); end
    vectors++; if ({operands_valid, busy, digit_err, display_bcd} !== 19'h0) begin miscompares++; $display("FAIL mid_rst_flags: got %b%b%b/%h want 000/0000", operands_valid, busy, digit_err, display_bcd); end
    enter_digit(4'd8);
    vectors++; if (display_bcd !== 16'h0008) begin miscompares++; $display("FAIL post_rst_digit: got %h want 0008", display_bcd); end
  endtask

  initial begin
    test_reset();
    test_first_operand();
    test_second_operand();
    test_short_and_full();
    test_digit_err();
    test_clear_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
